// File: rtl/jellyvl_divider_signed_adapter_if.sv
// Operand/result handshake channel for the signed divider adapter.
// Field a carries dividend or quotient, field b carries divisor or remainder.
interface jellyvl_divider_signed_adapter_if #(
    parameter int AW = 32,
    parameter int BW = 32
);
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          valid;
    logic          ready;

    modport master (
        output a,
        output b,
        output valid,
        input  ready
    );

    modport slave (
        input  a,
        input  b,
        input  valid,
        output ready
    );
endinterface

// File: rtl/jellyvl_divider_signed_adapter.sv
// Signed front/back end for the unsigned multicycle divider.
// Truncating (C) semantics; per-request sign info travels in a small FIFO.
module jellyvl_divider_signed_adapter #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cke,
    jellyvl_divider_signed_adapter_if.slave  s_if,
    jellyvl_divider_signed_adapter_if.master d_if,
    jellyvl_divider_signed_adapter_if.slave  r_if,
    jellyvl_divider_signed_adapter_if.master m_if,
    output logic m_div0
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic div0;
    } sign_t;

    logic          d_valid_q, d_valid_d;
    logic [DW-1:0] d_dividend_q, d_dividend_d;
    logic [VW-1:0] d_divisor_q, d_divisor_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_quot_q, m_quot_d;
    logic [VW-1:0] m_rem_q, m_rem_d;
    logic          m_div0_q, m_div0_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    sign_t         fifo_q [FIFO_DEPTH];
    sign_t         head;
    sign_t         push_ent;

    logic s_ready, s_fire, d_fire;
    logic r_ready, r_fire, m_fire;

    assign s_ready = (!d_valid_q || d_if.ready) && (count_q < FULL);
    assign r_ready = (!m_valid_q || m_if.ready) && (count_q != '0);
    assign s_fire  = cke && s_if.valid && s_ready;
    assign d_fire  = cke && d_valid_q && d_if.ready;
    assign r_fire  = cke && r_if.valid && r_ready;
    assign m_fire  = cke && m_valid_q && m_if.ready;

    assign head           = fifo_q[rptr_q];
    assign push_ent.neg_q = s_if.a[DW-1] ^ s_if.b[VW-1];
    assign push_ent.neg_r = s_if.a[DW-1];
    assign push_ent.div0  = (s_if.b == '0);

    always_comb begin
        d_valid_d    = d_valid_q;
        d_dividend_d = d_dividend_q;
        d_divisor_d  = d_divisor_q;
        m_valid_d    = m_valid_q;
        m_quot_d     = m_quot_q;
        m_rem_d      = m_rem_q;
        m_div0_d     = m_div0_q;
        count_d      = count_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;

        // Most negative value negates to itself, which is its correct unsigned magnitude
        if (s_fire) begin
            d_valid_d    = 1'b1;
            d_dividend_d = s_if.a[DW-1] ? -s_if.a : s_if.a;
            d_divisor_d  = s_if.b[VW-1] ? -s_if.b : s_if.b;
            wptr_d       = wptr_q + 1'b1;
        end else if (d_fire) begin
            d_valid_d = 1'b0;
        end

        if (r_fire) begin
            m_valid_d = 1'b1;
            m_quot_d  = head.neg_q ? -r_if.a : r_if.a;
            m_rem_d   = head.neg_r ? -r_if.b : r_if.b;
            m_div0_d  = head.div0;
            rptr_d    = rptr_q + 1'b1;
        end else if (m_fire) begin
            m_valid_d = 1'b0;
        end

        case ({s_fire, r_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid_q <= 1'b0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        d_dividend_q <= d_dividend_d;
        d_divisor_q  <= d_divisor_d;
        m_quot_q     <= m_quot_d;
        m_rem_q      <= m_rem_d;
        m_div0_q     <= m_div0_d;
        if (s_fire && !reset) begin
            fifo_q[wptr_q] <= push_ent;
        end
    end

    assign s_if.ready = s_ready;
    assign r_if.ready = r_ready;
    assign d_if.a     = d_dividend_q;
    assign d_if.b     = d_divisor_q;
    assign d_if.valid = d_valid_q;
    assign m_if.a     = m_quot_q;
    assign m_if.b     = m_rem_q;
    assign m_if.valid = m_valid_q;
    assign m_div0     = m_div0_q;
endmodule

// File: tb/tb_jellyvl_divider_signed_adapter.sv
// Bench for the signed divider adapter with an attached unsigned divider model.
// Results are checked against C truncating-division arithmetic.
module tb_jellyvl_divider_signed_adapter;
    logic clk = 1'b0;
    logic reset;
    logic cke;
    logic m_div0;

    always #5 clk = ~clk;

    jellyvl_divider_signed_adapter_if #(32, 32) s_if ();
    jellyvl_divider_signed_adapter_if #(32, 32) d_if ();
    jellyvl_divider_signed_adapter_if #(32, 32) r_if ();
    jellyvl_divider_signed_adapter_if #(32, 32) m_if ();

    jellyvl_divider_signed_adapter #(
        .DIVIDEND_WIDTH(32),
        .DIVISOR_WIDTH (32),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cke   (cke),
        .s_if  (s_if),
        .d_if  (d_if),
        .r_if  (r_if),
        .m_if  (m_if),
        .m_div0(m_div0)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    bit   rnd       = 1'b0;
    int   lat_min   = 6;
    int   lat_max   = 6;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Unsigned divider model: in-order, per-request random latency.
    // Division by zero returns all-ones quotient and the dividend as remainder.
    logic [31:0] mq_q[$];
    logic [31:0] mq_r[$];
    int          mdue[$];
    int          cyc = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq_q.delete();
            mq_r.delete();
            mdue.delete();
            r_if.valid <= 1'b0;
            d_if.ready <= 1'b1;
        end else if (cke) begin
            cyc++;
            if (r_if.valid && r_if.ready) begin
                void'(mq_q.pop_front());
                void'(mq_r.pop_front());
                void'(mdue.pop_front());
            end
            if (d_if.valid && d_if.ready) begin
                if (d_if.b == 32'd0) begin
                    mq_q.push_back(32'hFFFF_FFFF);
                    mq_r.push_back(d_if.a);
                end else begin
                    mq_q.push_back(d_if.a / d_if.b);
                    mq_r.push_back(d_if.a % d_if.b);
                end
                mdue.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            end
            if (mq_q.size() != 0) begin
                r_if.valid <= (mdue[0] <= cyc);
                r_if.a     <= mq_q[0];
                r_if.b     <= mq_r[0];
            end else begin
                r_if.valid <= 1'b0;
            end
            d_if.ready <= rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Result monitor: ordered scoreboard plus hold-stability of m outputs.
    logic        hold_prev = 1'b0;
    logic [65:0] hold_val;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (hold_prev) begin
            chk("m_hold", {m_if.valid, m_if.a, m_if.b, m_div0}, hold_val);
        end
        hold_prev = !reset && m_if.valid && !(m_if.ready && cke);
        hold_val  = {1'b1, m_if.a, m_if.b, m_div0};
        if (!reset && cke && m_if.valid && m_if.ready) begin
            n_asserts++;
            assert (sb.size() != 0)
            else begin
                n_fail++;
                $error("FAIL m_unexpected: observed result %h/%h expected none",
                       m_if.a, m_if.b);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("m_quotient", m_if.a, e.q);
                chk("m_remainder", m_if.b, e.r);
                chk("m_div0", m_div0, e.z);
            end
        end
    end

    function automatic void ref_div(input int a, input int b,
                                    output logic [31:0] q,
                                    output logic [31:0] r,
                                    output logic z);
        z = (b == 0);
        if (b == 0) begin
            q = (a < 0) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (a == int'(32'h8000_0000) && b == -1) begin
            q = a;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return -1;
            3:       return int'(32'h8000_0000);
            4:       return 32'h7FFF_FFFF;
            5:       return int'($urandom_range(0, 20)) - 10;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rnd) begin
            m_if.ready = ($urandom_range(0, 3) != 0);
            cke        = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic send(input int a, input int b, input logic [31:0] eq,
                        input logic [31:0] er, input logic ez);
        exp_t e;
        int   t = 0;
        s_if.a     = a;
        s_if.b     = b;
        s_if.valid = 1'b1;
        while (!(s_if.ready && cke) && t < 1000) begin
            tick();
            t++;
        end
        chk("s_accept_timeout", (t < 1000), 1'b1);
        e.q = eq;
        e.r = er;
        e.z = ez;
        sb.push_back(e);
        tick();
        s_if.valid = 1'b0;
    endtask

    task automatic send_ref(input int a, input int b);
        logic [31:0] q, r;
        logic        z;
        ref_div(a, b, q, r, z);
        send(a, b, q, r, z);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic wait_m_valid();
        int t = 0;
        while (!m_if.valid && t < 200) begin
            tick();
            t++;
        end
        chk("m_valid_timeout", m_if.valid, 1'b1);
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        cke         = 1'b1;
        s_if.valid  = 1'b0;
        s_if.a      = '0;
        s_if.b      = '0;
        m_if.ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_s_ready", s_if.ready, 1'b1);
        chk("rst_r_ready", r_if.ready, 1'b0);
        chk("rst_m_valid", m_if.valid, 1'b0);
        chk("rst_d_valid", d_if.valid, 1'b0);
        chk("rst_count", 32'(dut.count_q), 0);

        // Sign combinations
        m_if.ready = 1'b1;
        send(7, 2, 3, 1, 0);
        send(-7, 2, -3, -1, 0);
        send(7, -2, -3, 1, 0);
        send(-7, -2, 3, -1, 0);
        drain(200);

        send(int'(32'h8000_0000), int'(32'hFFFF_FFFF), 32'h8000_0000, 0, 0);
        drain(200);

        send(5, 0, 32'hFFFF_FFFF, 5, 1);
        send(6, 3, 2, 0, 0);
        drain(200);

        // FIFO full with results blocked
        m_if.ready = 1'b0;
        lat_min    = 8;
        lat_max    = 8;
        send(10, 3, 3, 1, 0);
        send(20, 3, 6, 2, 0);
        send(30, 3, 10, 0, 0);
        send(40, 3, 13, 1, 0);
        chk("full_s_ready", s_if.ready, 1'b0);
        chk("full_count", 32'(dut.count_q), 4);
        wait_m_valid();
        repeat (4) begin
            chk("blk_r_ready", r_if.ready, 1'b0);
            chk("blk_m_valid", m_if.valid, 1'b1);
            tick();
        end
        m_if.ready = 1'b1;
        drain(400);
        chk("drain_s_ready", s_if.ready, 1'b1);
        lat_min = 6;
        lat_max = 6;

        // Clock enable freezes the d handshake
        send(100, 7, 14, 2, 0);
        cke = 1'b0;
        repeat (3) tick();
        chk("cke_d_valid", d_if.valid, 1'b1);
        chk("cke_d_dividend", d_if.a, 100);
        chk("cke_d_divisor", d_if.b, 7);
        chk("cke_count", 32'(dut.count_q), 1);
        chk("cke_no_accept", mq_q.size(), 0);
        cke = 1'b1;
        t = 0;
        while (!(r_if.valid && r_if.ready) && t < 200) begin
            tick();
            t++;
        end
        chk("r_hs_timeout", (t < 200), 1'b1);
        cke = 1'b0;
        repeat (3) tick();
        chk("cke_r_valid", r_if.valid, 1'b1);
        chk("cke_m_valid", m_if.valid, 1'b0);
        chk("cke_r_count", 32'(dut.count_q), 1);
        cke = 1'b1;
        drain(200);

        // Clock enable freezes the m handshake
        m_if.ready = 1'b0;
        send(-100, 7, -14, -2, 0);
        wait_m_valid();
        cke        = 1'b0;
        m_if.ready = 1'b1;
        repeat (3) tick();
        chk("cke_m_hold_valid", m_if.valid, 1'b1);
        chk("cke_m_hold_q", m_if.a, 32'hFFFF_FFF2);
        chk("cke_m_pending", sb.size(), 1);
        cke = 1'b1;
        drain(200);

        // Reset with requests outstanding
        m_if.ready = 1'b0;
        send(50, 3, 16, 2, 0);
        send(51, 3, 17, 0, 0);
        wait_m_valid();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        chk("rst2_m_valid", m_if.valid, 1'b0);
        chk("rst2_s_ready", s_if.ready, 1'b1);
        chk("rst2_r_ready", r_if.ready, 1'b0);
        chk("rst2_count", 32'(dut.count_q), 0);
        m_if.ready = 1'b1;
        send(9, 4, 2, 1, 0);
        drain(200);

        // Random traffic against the arithmetic reference
        rnd     = 1'b1;
        lat_min = 1;
        lat_max = 5;
        for (int i = 0; i < 300; i++) begin
            int a, b;
            a = pick();
            b = ($urandom_range(0, 9) == 0) ? 0 : pick();
            send_ref(a, b);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd        = 1'b0;
        cke        = 1'b1;
        m_if.ready = 1'b1;
        drain(5000);
        chk("end_count", 32'(dut.count_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end
endmodule
